// File: rtl/ir_packet_tx.sv
// IR command packet generator for one remote-control car colour: emits
// Start, CarSelect, Right, Left, Backward, Forward carrier bursts with gaps.
module ir_packet_tx #(
    parameter int unsigned CARRIER_HALF_PERIOD   = 625,
    parameter int unsigned START_BURST_SIZE      = 88,
    parameter int unsigned CAR_SELECT_BURST_SIZE = 22,
    parameter int unsigned GAP_SIZE              = 40,
    parameter int unsigned ASSERT_BURST_SIZE     = 44,
    parameter int unsigned DEASSERT_BURST_SIZE   = 22
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SEND_PACKET,
    input  logic [3:0] COMMAND,
    output logic       BUSY,
    output logic       PACKET_DONE,
    output logic       IR_LED
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_SIZE = max2(max2(START_BURST_SIZE, CAR_SELECT_BURST_SIZE),
                                            max2(GAP_SIZE, max2(ASSERT_BURST_SIZE, DEASSERT_BURST_SIZE)));
    localparam int unsigned PW = $clog2(MAX_SIZE + 1);
    localparam int unsigned HW = (CARRIER_HALF_PERIOD > 1) ? $clog2(CARRIER_HALF_PERIOD) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_GAP1, S_SELECT, S_GAP2, S_RIGHT,
        S_GAP3, S_LEFT, S_GAP4, S_BACK, S_GAP5, S_FWD
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   half_q, half_d;
    logic            phase_q, phase_d;
    logic [PW-1:0]   per_q, per_d;
    logic [3:0]      cmd_q, cmd_d;
    logic            led_q, led_d;
    logic            done_q, done_d;

    logic [PW-1:0]   size;
    logic            half_end;
    logic            period_end;
    logic            burst_next;

    function automatic logic [PW-1:0] dir_size(input logic bit_v);
        return bit_v ? PW'(ASSERT_BURST_SIZE) : PW'(DEASSERT_BURST_SIZE);
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            half_q  <= '0;
            phase_q <= 1'b0;
            per_q   <= '0;
            cmd_q   <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            phase_q <= phase_d;
            per_q   <= per_d;
            cmd_q   <= cmd_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        phase_d    = phase_q;
        per_d      = per_q;
        cmd_d      = cmd_q;
        done_d     = 1'b0;
        size       = PW'(GAP_SIZE);
        half_end   = (half_q == HW'(CARRIER_HALF_PERIOD - 1));
        period_end = half_end && !phase_q;

        case (state_q)
            S_START:  size = PW'(START_BURST_SIZE);
            S_SELECT: size = PW'(CAR_SELECT_BURST_SIZE);
            S_RIGHT:  size = dir_size(cmd_q[0]);
            S_LEFT:   size = dir_size(cmd_q[1]);
            S_BACK:   size = dir_size(cmd_q[2]);
            S_FWD:    size = dir_size(cmd_q[3]);
            default:  size = PW'(GAP_SIZE);
        endcase

        if (state_q == S_IDLE) begin
            // A request in the PACKET_DONE cycle is dropped; accepted from the next cycle.
            if (SEND_PACKET && !done_q) begin
                state_d = S_START;
                cmd_d   = COMMAND;
                half_d  = '0;
                phase_d = 1'b1;
                per_d   = '0;
            end
        end else begin
            if (half_end) begin
                half_d  = '0;
                phase_d = ~phase_q;
            end else begin
                half_d = half_q + HW'(1);
            end
            if (period_end) begin
                if (per_q == size - PW'(1)) begin
                    per_d = '0;
                    case (state_q)
                        S_START:  state_d = S_GAP1;
                        S_GAP1:   state_d = S_SELECT;
                        S_SELECT: state_d = S_GAP2;
                        S_GAP2:   state_d = S_RIGHT;
                        S_RIGHT:  state_d = S_GAP3;
                        S_GAP3:   state_d = S_LEFT;
                        S_LEFT:   state_d = S_GAP4;
                        S_GAP4:   state_d = S_BACK;
                        S_BACK:   state_d = S_GAP5;
                        S_GAP5:   state_d = S_FWD;
                        default: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end else begin
                    per_d = per_q + PW'(1);
                end
            end
        end

        // LED is registered from next-state values so it tracks state without glitches.
        case (state_d)
            S_START, S_SELECT, S_RIGHT, S_LEFT, S_BACK, S_FWD: burst_next = 1'b1;
            default: burst_next = 1'b0;
        endcase
        led_d = burst_next && phase_d;
    end

    assign BUSY        = (state_q != S_IDLE);
    assign PACKET_DONE = done_q;
    assign IR_LED      = led_q;

endmodule

// File: tb/tb_ir_packet_tx.sv
// Directed bench for ir_packet_tx with reduced timing parameters: packet
// shape, burst lengths, request handling and asynchronous reset.
module tb_ir_packet_tx;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SEND_PACKET = 1'b0;
    logic [3:0] COMMAND = 4'b0000;
    logic       BUSY, PACKET_DONE, IR_LED;

    int total = 0;
    int bad = 0;

    ir_packet_tx #(
        .CARRIER_HALF_PERIOD(2),
        .START_BURST_SIZE(4),
        .CAR_SELECT_BURST_SIZE(2),
        .GAP_SIZE(3),
        .ASSERT_BURST_SIZE(3),
        .DEASSERT_BURST_SIZE(1)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .SEND_PACKET(SEND_PACKET),
        .COMMAND(COMMAND),
        .BUSY(BUSY),
        .PACKET_DONE(PACKET_DONE),
        .IR_LED(IR_LED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] cmd;
        logic [3:0] mid_cmd;
        bit         repulse;
        int         exp_busy;
        int         exp_burst[6];
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts at a negedge; leaves SEND_PACKET high at exit when chain is set so
    // the next packet is requested in the cycle after the one ignored at PACKET_DONE.
    task automatic run_packet(input int idx, input bit chain);
        bit led[0:1023];
        int cnt, done_in_busy, nseg, last_high;
        int seg_s[8], seg_e[8];
        string tag;
        tag = $sformatf("pkt%0d", idx);
        SEND_PACKET = 1'b1;
        COMMAND = vecs[idx].cmd;
        @(negedge CLK);
        SEND_PACKET = 1'b0;
        chk({tag, "_busy_first"}, int'(BUSY), 1);
        chk({tag, "_led_first"}, int'(IR_LED), 1);
        cnt = 0;
        done_in_busy = 0;
        while (BUSY && cnt < 1000) begin
            led[cnt] = IR_LED;
            if (PACKET_DONE) done_in_busy++;
            cnt++;
            if (cnt == 10) COMMAND = vecs[idx].mid_cmd;
            SEND_PACKET = vecs[idx].repulse && (cnt == 30 || cnt == 70);
            @(negedge CLK);
        end
        SEND_PACKET = 1'b0;
        chk({tag, "_busy_len"}, cnt, vecs[idx].exp_busy);
        chk({tag, "_done_at_end"}, int'(PACKET_DONE), 1);
        chk({tag, "_done_early"}, done_in_busy, 0);
        chk({tag, "_start_1100"}, int'({led[0], led[1], led[2], led[3]}), 12);
        nseg = 0;
        last_high = -100;
        for (int i = 0; i < cnt; i++) begin
            if (led[i]) begin
                if (i - last_high > 3 && nseg < 8) begin
                    seg_s[nseg] = i;
                    nseg++;
                end
                if (nseg > 0) seg_e[nseg-1] = i;
                last_high = i;
            end
        end
        chk({tag, "_nbursts"}, nseg, 6);
        for (int b = 0; b < 6; b++) begin
            if (b < nseg)
                chk($sformatf("%s_burst%0d", tag, b), (seg_e[b] - seg_s[b] + 3) / 4,
                    vecs[idx].exp_burst[b]);
            else
                chk($sformatf("%s_burst%0d", tag, b), 0, vecs[idx].exp_burst[b]);
        end
        SEND_PACKET = chain;
        @(negedge CLK);
        chk({tag, "_req_at_done_ignored"}, int'(BUSY), 0);
        chk({tag, "_done_one_cycle"}, int'(PACKET_DONE), 0);
        chk({tag, "_led_idle"}, int'(IR_LED), 0);
    endtask

    initial begin
        int highs;
        vecs[0] = '{cmd: 4'b0000, mid_cmd: 4'b1111, repulse: 1'b0, exp_busy: 100,
                    exp_burst: '{4, 2, 1, 1, 1, 1}};
        vecs[1] = '{cmd: 4'b1111, mid_cmd: 4'b0000, repulse: 1'b0, exp_busy: 132,
                    exp_burst: '{4, 2, 3, 3, 3, 3}};
        vecs[2] = '{cmd: 4'b0101, mid_cmd: 4'b1010, repulse: 1'b1, exp_busy: 116,
                    exp_burst: '{4, 2, 3, 1, 3, 1}};
        vecs[3] = '{cmd: 4'b1000, mid_cmd: 4'b0111, repulse: 1'b1, exp_busy: 108,
                    exp_burst: '{4, 2, 1, 1, 1, 3}};
        vecs[4] = '{cmd: 4'b0010, mid_cmd: 4'b1101, repulse: 1'b0, exp_busy: 108,
                    exp_burst: '{4, 2, 1, 3, 1, 1}};

        #12;
        chk("rst_led", int'(IR_LED), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(PACKET_DONE), 0);
        @(negedge CLK);
        RESET = 1'b0;
        highs = 0;
        repeat (20) begin
            @(negedge CLK);
            highs += int'(IR_LED) + int'(BUSY) + int'(PACKET_DONE);
        end
        chk("idle_quiet", highs, 0);

        // Reset in GAP3 (cycles 52..63 after accept for COMMAND=0).
        SEND_PACKET = 1'b1;
        COMMAND = 4'b0000;
        @(negedge CLK);
        SEND_PACKET = 1'b0;
        repeat (56) @(negedge CLK);
        chk("gap3_busy", int'(BUSY), 1);
        chk("gap3_led", int'(IR_LED), 0);
        #1 RESET = 1'b1;
        #1;
        chk("async_rst_busy", int'(BUSY), 0);
        chk("async_rst_led", int'(IR_LED), 0);
        chk("async_rst_done", int'(PACKET_DONE), 0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        for (int v = 0; v < 5; v++) run_packet(v, v < 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
